// File: rtl/fnd_scan_controller.sv
// fnd_scan_controller
// Converts a 14-bit binary value to four BCD digits with a sequential
// double-dabble engine, then time-multiplexes the digits onto the FND
// select/font decoders. The last completed conversion stays on the display
// while a new one runs.
// Optional build macro: FND_LEADING_ZERO_BLANK_EN (blank leading zero digits).

module fnd_scan_controller #(
   parameter int CLK_DIV = 100000
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_load,
   input  logic [13:0] i_data,
   output logic        o_busy,
   output logic        o_overflow,
   output logic [1:0]  o_digitSelect,
   output logic [3:0]  o_value,
   output logic        o_en
);

   localparam int PRESCALE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t      state_q, state_d;
   logic [13:0] operand_q, operand_d;
   logic [15:0] scratch_q, scratch_d;
   logic [3:0]  iterCount_q, iterCount_d;
   logic        overflowNext_q, overflowNext_d;
   logic        busy_q, busy_d;
   logic        overflow_q, overflow_d;
   logic [15:0] display_q, display_d;
   logic        valid_q, valid_d;

   logic [PRESCALE_W-1:0] prescaler_q;
   logic                  scanTick;
   logic [1:0]            index_q;

   logic [1:0]  digitSelect_q;
   logic [3:0]  value_q;
   logic        en_q;
   logic [3:0]  selNibble;
   logic        enNext;
   logic [15:0] adjusted;

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 before the shift.
   function automatic logic [15:0] addThree(input logic [15:0] bcd);
      logic [15:0] res;
      res = bcd;
      for (int n = 0; n < 4; n++) begin
         if (bcd[4*n +: 4] >= 4'd5) begin
            res[4*n +: 4] = bcd[4*n +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

   assign adjusted = addThree(scratch_q);

   // Conversion FSM state and datapath registers.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q        <= IDLE;
         operand_q      <= '0;
         scratch_q      <= '0;
         iterCount_q    <= '0;
         overflowNext_q <= 1'b0;
         busy_q         <= 1'b0;
         overflow_q     <= 1'b0;
         display_q      <= '0;
         valid_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         operand_q      <= operand_d;
         scratch_q      <= scratch_d;
         iterCount_q    <= iterCount_d;
         overflowNext_q <= overflowNext_d;
         busy_q         <= busy_d;
         overflow_q     <= overflow_d;
         display_q      <= display_d;
         valid_q        <= valid_d;
      end
   end

   // Next-state logic; SHIFT spends one terminal cycle at count 0 before DONE,
   // so busy (registered from the SHIFT state) spans exactly 15 cycles.
   always_comb begin
      state_d        = state_q;
      operand_d      = operand_q;
      scratch_d      = scratch_q;
      iterCount_d    = iterCount_q;
      overflowNext_d = overflowNext_q;
      busy_d         = busy_q;
      overflow_d     = overflow_q;
      display_d      = display_q;
      valid_d        = valid_q;

      case (state_q)
         IDLE: begin
            busy_d = 1'b0;
            if (i_load) begin
               if (i_data > 14'd9999) begin
                  operand_d      = 14'd9999;
                  overflowNext_d = 1'b1;
               end else begin
                  operand_d      = i_data;
                  overflowNext_d = 1'b0;
               end
               scratch_d   = '0;
               iterCount_d = 4'd14;
               state_d     = SHIFT;
            end
         end
         SHIFT: begin
            busy_d = 1'b1;
            if (iterCount_q == 4'd0) begin
               state_d = DONE;
            end else begin
               {scratch_d, operand_d} = {adjusted, operand_q} << 1;
               iterCount_d            = iterCount_q - 4'd1;
            end
         end
         DONE: begin
            display_d  = scratch_q;
            overflow_d = overflowNext_q;
            valid_d    = 1'b1;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign scanTick = (prescaler_q == PRESCALE_MAX);

   // Scan prescaler: counts 0..CLK_DIV-1 and wraps on the tick.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         prescaler_q <= '0;
      end else if (scanTick) begin
         prescaler_q <= '0;
      end else begin
         prescaler_q <= prescaler_q + 1'b1;
      end
   end

   // Free-running digit index, advanced once per scan tick.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         index_q <= 2'd0;
      end else if (scanTick) begin
         index_q <= index_q + 2'd1;
      end
   end

   assign selNibble = display_q[{index_q, 2'b00} +: 4];

`ifdef FND_LEADING_ZERO_BLANK_EN
   logic [1:0] msdIndex;

   // Locate the most significant non-zero digit; digit 0 is always shown.
   always_comb begin
      msdIndex = 2'd0;
      if (display_q[7:4] != 4'd0) begin
         msdIndex = 2'd1;
      end
      if (display_q[11:8] != 4'd0) begin
         msdIndex = 2'd2;
      end
      if (display_q[15:12] != 4'd0) begin
         msdIndex = 2'd3;
      end
      enNext = valid_q && (index_q <= msdIndex);
   end
`else
   assign enNext = valid_q;
`endif

   // Registered decoder outputs, updated together so select and value stay coherent.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         digitSelect_q <= 2'd0;
         value_q       <= 4'd0;
         en_q          <= 1'b0;
      end else begin
         digitSelect_q <= index_q;
         value_q       <= selNibble;
         en_q          <= enNext;
      end
   end

   assign o_busy        = busy_q;
   assign o_overflow    = overflow_q;
   assign o_digitSelect = digitSelect_q;
   assign o_value       = value_q;
   assign o_en          = en_q;

endmodule

// File: tb/tb_fnd_scan_controller.sv
// tb_fnd_scan_controller
// Scoreboard bench: expected BCD/overflow pushed when a load is driven,
// popped when busy falls; the scanned digit stream is then compared.
// Honours FND_LEADING_ZERO_BLANK_EN for the expected enables.

module tb_fnd_scan_controller;

   localparam int CLK_DIV = 4;

   logic        clk;
   logic        i_reset_n;
   logic        i_load;
   logic [13:0] i_data;
   logic        o_busy;
   logic        o_overflow;
   logic [1:0]  o_digitSelect;
   logic [3:0]  o_value;
   logic        o_en;

   typedef struct {
      logic [15:0] bcd;
      logic        ovf;
   } expect_t;

   expect_t     sbQueue[$];
   int          errors;
   int          checks;
   bit          modelValid;
   logic [15:0] bcd;

   fnd_scan_controller #(.CLK_DIV(CLK_DIV)) dut (
      .i_clk        (clk),
      .i_reset_n    (i_reset_n),
      .i_load       (i_load),
      .i_data       (i_data),
      .o_busy       (o_busy),
      .o_overflow   (o_overflow),
      .o_digitSelect(o_digitSelect),
      .o_value      (o_value),
      .o_en         (o_en)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run can never hang.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
      end
   endtask

   function automatic logic [15:0] toBcd(input int v);
      int d;
      d = (v > 9999) ? 9999 : v;
      return {4'(d / 1000), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
   endfunction

   function automatic bit expEn(input logic [15:0] b, input int digit, input bit valid);
      int msd;
      bit blank;
      msd   = 0;
      blank = 1'b0;
      for (int n = 1; n < 4; n++) begin
         if (b[4*n +: 4] != 4'd0) msd = n;
      end
`ifdef FND_LEADING_ZERO_BLANK_EN
      blank = (digit > msd);
`endif
      return valid && !blank;
   endfunction

   // Drive a one-cycle load; push the expected result when it should complete.
   task automatic applyStimulus(input int value, input bit expectDone);
      expect_t e;
      @(negedge clk);
      i_load = 1'b1;
      i_data = 14'(value);
      if (expectDone) begin
         e.bcd = toBcd(value);
         e.ovf = (value > 9999);
         sbQueue.push_back(e);
      end
      @(negedge clk);
      i_load = 1'b0;
   endtask

   // Count the busy window, optionally pulse a load at busy cycle pulseAt,
   // then pop the scoreboard and compare overflow.
   task automatic waitConversion(input int pulseAt, input int pulseData, output logic [15:0] expBcd);
      int      busyCycles;
      bit      seenFall;
      expect_t e;
      busyCycles = 0;
      seenFall   = 1'b0;
      expBcd     = '0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         i_load = 1'b0;
         if (o_busy) begin
            busyCycles++;
         end else if (busyCycles > 0) begin
            seenFall = 1'b1;
            break;
         end
         if (k == pulseAt) begin
            i_load = 1'b1;
            i_data = 14'(pulseData);
         end
      end
      i_load = 1'b0;
      checkOutput("busyCycles", busyCycles, 15);
      checkOutput("busyFall", int'(seenFall), 1);
      if (sbQueue.size() > 0) begin
         e      = sbQueue.pop_front();
         expBcd = e.bcd;
         checkOutput("overflow", int'(o_overflow), int'(e.ovf));
         if (seenFall) modelValid = 1'b1;
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("noRestart", int'(o_busy), 0);
      end
   endtask

   // Align to a 3->0 select wrap, then check one full scan of 4*CLK_DIV cycles.
   task automatic scanCheck(input logic [15:0] expBcd, input string tag);
      logic [1:0] prev;
      bit         found;
      int         d;
      found = 1'b0;
      prev  = o_digitSelect;
      for (int k = 0; k < 8 * CLK_DIV; k++) begin
         @(negedge clk);
         if (prev == 2'd3 && o_digitSelect == 2'd0) begin
            found = 1'b1;
            break;
         end
         prev = o_digitSelect;
      end
      checkOutput({tag, "_align"}, int'(found), 1);
      for (int i = 0; i < 4 * CLK_DIV; i++) begin
         if (i > 0) @(negedge clk);
         d = i / CLK_DIV;
         checkOutput($sformatf("%s_sel%0d", tag, i), int'(o_digitSelect), d);
         checkOutput($sformatf("%s_val%0d", tag, i), int'(o_value), int'(expBcd[4*d +: 4]));
         checkOutput($sformatf("%s_en%0d", tag, i), int'(o_en), int'(expEn(expBcd, d, modelValid)));
      end
   endtask

   // Main sequence.
   initial begin
      errors     = 0;
      checks     = 0;
      modelValid = 1'b0;
      i_reset_n  = 1'b0;
      i_load     = 1'b0;
      i_data     = '0;

      repeat (3) @(negedge clk);
      checkOutput("rstEn", int'(o_en), 0);
      checkOutput("rstBusy", int'(o_busy), 0);
      checkOutput("rstOvf", int'(o_overflow), 0);
      checkOutput("rstSel", int'(o_digitSelect), 0);
      checkOutput("rstVal", int'(o_value), 0);
      i_reset_n = 1'b1;
      scanCheck(16'h0000, "postReset");

      applyStimulus(1234, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d1234");

      applyStimulus(12000, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d12000");

      applyStimulus(7, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d7");

      applyStimulus(5678, 1'b1);
      waitConversion(5, 1111, bcd);
      scanCheck(bcd, "d5678");

      applyStimulus(2468, 1'b1);
      waitConversion(15, 1357, bcd);
      scanCheck(bcd, "d2468");

      applyStimulus(4321, 1'b0);
      repeat (7) @(negedge clk);
      checkOutput("midBusy", int'(o_busy), 1);
      i_reset_n = 1'b0;
      @(negedge clk);
      checkOutput("abortBusy", int'(o_busy), 0);
      checkOutput("abortEn", int'(o_en), 0);
      checkOutput("abortOvf", int'(o_overflow), 0);
      checkOutput("abortSel", int'(o_digitSelect), 0);
      checkOutput("abortVal", int'(o_value), 0);
      i_reset_n  = 1'b1;
      modelValid = 1'b0;
      scanCheck(16'h0000, "abortScan");

      applyStimulus(9, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d9");

      applyStimulus(42, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d42");

      applyStimulus(0, 1'b1);
      waitConversion(0, 0, bcd);
      scanCheck(bcd, "d0");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
